// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multicycle RV32I main control sequencer
//
// Purpose: steps fetch/decode/execute/memory/writeback for one instruction at a
// time and drives the datapath steering signals each cycle.
//
// Ports:
//   clk                      system clock, rising edge
//   reset                    asynchronous active-low reset
//   instr[31:0]              latched instruction register
//   zero/carry/sign/overflow ALU flags (carry = 1 means no borrow)
//   pc_write, adr_src, mem_write, ir_write, reg_write   datapath enables/selects
//   result_src[1:0], alu_src_a[1:0], alu_src_b[1:0]     datapath mux selects
//   alu_control[3:0], imm_src[2:0]                      ALU op / immediate format
//   illegal                  sticky unsupported-opcode flag
//   state_dbg[3:0]           current state encoding
module multicycle_control_fsm #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        carry,
  input  logic        sign,
  input  logic        overflow,
  output logic        pc_write,
  output logic        adr_src,
  output logic        mem_write,
  output logic        ir_write,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_control,
  output logic [2:0]  imm_src,
  output logic        reg_write,
  output logic        illegal,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR_ADR  = 4'd11,
    S_JALR_PC   = 4'd12,
    S_LUI       = 4'd13,
    S_AUIPC     = 4'd14,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Final wait-counter value of a FETCH or MEM_READ burst.
  localparam logic [2:0] LAST_WAIT = 3'(MEM_LATENCY - 1);

  state_t     state, state_next;
  logic [2:0] wait_cnt, wait_next;
  logic       illegal_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       wait_done;
  logic       branch_taken;
  logic [3:0] r_op, i_op;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7b5  = instr[30];
  assign wait_done = (wait_cnt == LAST_WAIT);

  logic unused_instr_bits;
  assign unused_instr_bits = &{1'b0, instr[31], instr[29:15], instr[11:7]};

  // State register, wait counter and sticky illegal flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      wait_cnt  <= 3'd0;
      illegal_q <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      if (state_next == S_TRAP) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // Next state. The wait counter only advances while a memory burst is
  // still pending; every other path leaves it at zero for the next state.
  always_comb begin
    state_next = state;
    wait_next  = 3'd0;
    unique case (state)
      S_FETCH: begin
        if (wait_done) state_next = S_DECODE;
        else           wait_next  = wait_cnt + 3'd1;
      end
      S_DECODE: begin
        unique case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
          OP_R:              state_next = S_EXEC_R;
          OP_I:              state_next = S_EXEC_I;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR_ADR;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEM_ADR:   state_next = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (wait_done) state_next = S_MEM_WB;
        else           wait_next  = wait_cnt + 3'd1;
      end
      S_MEM_WB:    state_next = S_FETCH;
      S_MEM_WRITE: state_next = S_FETCH;
      S_EXEC_R:    state_next = S_ALU_WB;
      S_EXEC_I:    state_next = S_ALU_WB;
      S_ALU_WB:    state_next = S_FETCH;
      S_BRANCH:    state_next = S_FETCH;
      S_JAL:       state_next = S_ALU_WB;
      S_JALR_ADR:  state_next = S_JALR_PC;
      S_JALR_PC:   state_next = S_ALU_WB;
      S_LUI:       state_next = S_ALU_WB;
      S_AUIPC:     state_next = S_ALU_WB;
      S_TRAP:      state_next = S_TRAP;
      default:     state_next = S_FETCH;
    endcase
  end

  // ALU operation for register and immediate arithmetic. Only the shift
  // group uses funct7b5 for immediates, so addi never turns into a subtract.
  always_comb begin
    r_op = ALU_ADD;
    i_op = ALU_ADD;
    unique case (funct3)
      3'b000: begin r_op = funct7b5 ? ALU_SUB : ALU_ADD; i_op = ALU_ADD; end
      3'b001: begin r_op = ALU_SLL;  i_op = ALU_SLL;  end
      3'b010: begin r_op = ALU_SLT;  i_op = ALU_SLT;  end
      3'b011: begin r_op = ALU_SLTU; i_op = ALU_SLTU; end
      3'b100: begin r_op = ALU_XOR;  i_op = ALU_XOR;  end
      3'b101: begin
        r_op = funct7b5 ? ALU_SRA : ALU_SRL;
        i_op = funct7b5 ? ALU_SRA : ALU_SRL;
      end
      3'b110: begin r_op = ALU_OR;   i_op = ALU_OR;   end
      default: begin r_op = ALU_AND; i_op = ALU_AND;  end
    endcase
  end

  // Branch condition from the subtract flags of rs1 - rs2.
  always_comb begin
    branch_taken = 1'b0;
    unique case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = !zero;
      3'b100:  branch_taken = sign ^ overflow;
      3'b101:  branch_taken = !(sign ^ overflow);
      3'b110:  branch_taken = !carry;
      3'b111:  branch_taken = carry;
      default: branch_taken = 1'b0;
    endcase
  end

  // Datapath controls. Everything is held at zero while reset is asserted so
  // an aborted instruction cannot leak a write strobe.
  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    imm_src     = IMM_I;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    state_dbg   = 4'd0;
    if (reset) begin
      illegal   = illegal_q;
      state_dbg = state;
      unique case (state)
        S_FETCH: begin
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = wait_done;
          pc_write   = wait_done;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        end
        S_MEM_ADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        end
        S_MEM_READ: begin
          adr_src = 1'b1;
        end
        S_MEM_WB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
        end
        S_MEM_WRITE: begin
          adr_src   = 1'b1;
          mem_write = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a   = 2'b10;
          alu_control = r_op;
        end
        S_EXEC_I: begin
          alu_src_a   = 2'b10;
          alu_src_b   = 2'b01;
          alu_control = i_op;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a   = 2'b10;
          alu_control = ALU_SUB;
          pc_write    = branch_taken;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        S_JALR_ADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        S_JALR_PC: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        S_LUI: begin
          alu_src_b   = 2'b01;
          imm_src     = IMM_U;
          alu_control = ALU_PASSB;
        end
        S_AUIPC: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_src   = IMM_U;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

  typedef logic [22:0] vec_t;

  typedef struct {
    logic [31:0] ins;
    logic        z, c, s, v;
    int          cyc;
    logic        pcw;
  } rec_t;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEM_ADR = 4'd2,
    ST_MEM_READ = 4'd3, ST_MEM_WB = 4'd4, ST_MEM_WRITE = 4'd5, ST_EXEC_R = 4'd6,
    ST_EXEC_I = 4'd7, ST_ALU_WB = 4'd8, ST_BRANCH = 4'd9, ST_JAL = 4'd10,
    ST_JALR_ADR = 4'd11, ST_JALR_PC = 4'd12, ST_LUI = 4'd13, ST_AUIPC = 4'd14,
    ST_TRAP = 4'd15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0, carry = 1'b0, sign = 1'b0, overflow = 1'b0;

  logic        pc_write1, adr_src1, mem_write1, ir_write1, reg_write1, illegal1;
  logic [1:0]  result_src1, alu_src_a1, alu_src_b1;
  logic [3:0]  alu_control1, state_dbg1;
  logic [2:0]  imm_src1;
  logic        pc_write2, adr_src2, mem_write2, ir_write2, reg_write2, illegal2;
  logic [1:0]  result_src2, alu_src_a2, alu_src_b2;
  logic [3:0]  alu_control2, state_dbg2;
  logic [2:0]  imm_src2;

  multicycle_control_fsm #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .carry(carry),
    .sign(sign), .overflow(overflow), .pc_write(pc_write1), .adr_src(adr_src1),
    .mem_write(mem_write1), .ir_write(ir_write1), .result_src(result_src1),
    .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .alu_control(alu_control1),
    .imm_src(imm_src1), .reg_write(reg_write1), .illegal(illegal1),
    .state_dbg(state_dbg1)
  );

  multicycle_control_fsm #(.MEM_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .carry(carry),
    .sign(sign), .overflow(overflow), .pc_write(pc_write2), .adr_src(adr_src2),
    .mem_write(mem_write2), .ir_write(ir_write2), .result_src(result_src2),
    .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .alu_control(alu_control2),
    .imm_src(imm_src2), .reg_write(reg_write2), .illegal(illegal2),
    .state_dbg(state_dbg2)
  );

  always #5 clk = ~clk;

  vec_t vec1, vec2;
  assign vec1 = {state_dbg1, pc_write1, adr_src1, mem_write1, ir_write1, result_src1,
                 alu_src_a1, alu_src_b1, alu_control1, imm_src1, reg_write1, illegal1};
  assign vec2 = {state_dbg2, pc_write2, adr_src2, mem_write2, ir_write2, result_src2,
                 alu_src_a2, alu_src_b2, alu_control2, imm_src2, reg_write2, illegal2};

  int   errors = 0;
  int   checks = 0;
  vec_t exp_q[$];

  task automatic check_vec(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] st, input logic pcw, input logic adr,
                              input logic mw, input logic irw, input logic [1:0] rs,
                              input logic [1:0] sa, input logic [1:0] sb,
                              input logic [3:0] alu, input logic [2:0] imm,
                              input logic rw, input logic ill);
    return {st, pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, ill};
  endfunction

  // ALU op implied by funct3 for arithmetic; funct7b5 picks sub/sra where legal.
  function automatic logic [3:0] arith_op(input logic [31:0] ins, input bit is_r);
    logic [3:0] tbl [8];
    logic [2:0] f3;
    tbl = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    f3 = ins[14:12];
    if (ins[30] && f3 == 3'd5) return 4'd7;
    if (ins[30] && is_r && f3 == 3'd0) return 4'd1;
    return tbl[f3];
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic z, input logic c,
                                 input logic s, input logic v);
    int a = s ^ v;
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return a != 0;
      3'd5: return a == 0;
      3'd6: return !c;
      3'd7: return c;
      default: return 1'b0;
    endcase
  endfunction

  // Expected per-cycle output trace of one instruction.
  task automatic build(input logic [31:0] ins, input logic z, input logic c,
                       input logic s, input logic v, input int lat);
    logic [6:0] op = ins[6:0];
    vec_t alu_wb = mk(ST_ALU_WB, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, 1, 0);
    exp_q.delete();
    for (int k = 0; k < lat; k++) begin
      logic last = (k == lat - 1);
      exp_q.push_back(mk(ST_FETCH, last, 0, 0, last, 2'b10, 2'b00, 2'b10, 4'd0, 3'd0, 0, 0));
    end
    exp_q.push_back(mk(ST_DECODE, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'd0,
                       (op == 7'h6F) ? 3'd3 : 3'd2, 0, 0));
    case (op)
      7'h03: begin
        exp_q.push_back(mk(ST_MEM_ADR, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd0, 3'd0, 0, 0));
        for (int k = 0; k < lat; k++)
          exp_q.push_back(mk(ST_MEM_READ, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, 0, 0));
        exp_q.push_back(mk(ST_MEM_WB, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 4'd0, 3'd0, 1, 0));
      end
      7'h23: begin
        exp_q.push_back(mk(ST_MEM_ADR, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd0, 3'd1, 0, 0));
        exp_q.push_back(mk(ST_MEM_WRITE, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, 0, 0));
      end
      7'h33: begin
        exp_q.push_back(mk(ST_EXEC_R, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, arith_op(ins, 1), 3'd0, 0, 0));
        exp_q.push_back(alu_wb);
      end
      7'h13: begin
        exp_q.push_back(mk(ST_EXEC_I, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, arith_op(ins, 0), 3'd0, 0, 0));
        exp_q.push_back(alu_wb);
      end
      7'h63: begin
        exp_q.push_back(mk(ST_BRANCH, taken(ins[14:12], z, c, s, v), 0, 0, 0, 2'b00, 2'b10,
                           2'b00, 4'd1, 3'd0, 0, 0));
      end
      7'h6F: begin
        exp_q.push_back(mk(ST_JAL, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 4'd0, 3'd0, 0, 0));
        exp_q.push_back(alu_wb);
      end
      7'h67: begin
        exp_q.push_back(mk(ST_JALR_ADR, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd0, 3'd0, 0, 0));
        exp_q.push_back(mk(ST_JALR_PC, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 4'd0, 3'd0, 0, 0));
        exp_q.push_back(alu_wb);
      end
      7'h37: begin
        exp_q.push_back(mk(ST_LUI, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 4'd10, 3'd4, 0, 0));
        exp_q.push_back(alu_wb);
      end
      7'h17: begin
        exp_q.push_back(mk(ST_AUIPC, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'd0, 3'd4, 0, 0));
        exp_q.push_back(alu_wb);
      end
      default: begin
        exp_q.push_back(mk(ST_TRAP, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, 0, 1));
      end
    endcase
  endtask

  // Entered at a falling edge inside the first FETCH cycle; returns at the
  // falling edge inside the next instruction's first FETCH cycle.
  task automatic run_instr(input logic [31:0] ins, input logic z, input logic c,
                           input logic s, input logic v, input int sel,
                           output int cycles, output logic pcw_seen);
    vec_t act;
    bit   left = 0;
    bit   done = 0;
    instr = ins; zero = z; carry = c; sign = s; overflow = v;
    #1;
    build(ins, z, c, s, v, sel);
    cycles = 0;
    pcw_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      act = (sel == 2) ? vec2 : vec1;
      if (left && act[22:19] == ST_FETCH) begin
        done = 1;
        break;
      end
      if (i < exp_q.size()) check_vec($sformatf("cycle%0d_%h", i, ins), act, exp_q[i]);
      if (act[22:19] != ST_FETCH) left = 1;
      if (left && act[18]) pcw_seen = 1;
      cycles++;
    end
    if (!done) check_int($sformatf("return_to_fetch_%h", ins), 0, 1);
    check_int($sformatf("trace_len_%h", ins), cycles, exp_q.size());
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_vec("reset_out1", vec1, '0);
      check_vec("reset_out2", vec2, '0);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
  endtask

  rec_t tbl[16];
  int   cyc;
  logic pcw;

  initial begin
    tbl[0]  = '{32'h002081B3, 0, 0, 0, 0, 4, 0};
    tbl[1]  = '{32'h402081B3, 0, 0, 0, 0, 4, 0};
    tbl[2]  = '{32'h4010D093, 0, 0, 0, 0, 4, 0};
    tbl[3]  = '{32'h40008093, 0, 0, 0, 0, 4, 0};
    tbl[4]  = '{32'h0000A103, 0, 0, 0, 0, 5, 0};
    tbl[5]  = '{32'h0020A023, 0, 0, 0, 0, 4, 0};
    tbl[6]  = '{32'h00208463, 1, 0, 0, 0, 3, 1};
    tbl[7]  = '{32'h00208463, 0, 1, 1, 1, 3, 0};
    tbl[8]  = '{32'h0020E463, 0, 0, 0, 0, 3, 1};
    tbl[9]  = '{32'h0020F463, 1, 0, 0, 0, 3, 0};
    tbl[10] = '{32'h0020C463, 0, 1, 1, 0, 3, 1};
    tbl[11] = '{32'h0020D463, 0, 1, 1, 0, 3, 0};
    tbl[12] = '{32'h008000EF, 0, 0, 0, 0, 4, 1};
    tbl[13] = '{32'h000080E7, 0, 0, 0, 0, 5, 1};
    tbl[14] = '{32'h000010B7, 0, 0, 0, 0, 4, 0};
    tbl[15] = '{32'h00001097, 0, 0, 0, 0, 4, 0};

    // Reset, then the directed table back-to-back at MEM_LATENCY = 1.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      run_instr(tbl[i].ins, tbl[i].z, tbl[i].c, tbl[i].s, tbl[i].v, 1, cyc, pcw);
      check_int($sformatf("cycles_%0d", i), cyc, tbl[i].cyc);
      check_int($sformatf("pc_write_exec_%0d", i), int'(pcw), int'(tbl[i].pcw));
    end

    // MEM_LATENCY = 2: load takes 7 cycles, store 5.
    do_reset();
    run_instr(32'h0000A103, 0, 0, 0, 0, 2, cyc, pcw);
    check_int("lat2_load_cycles", cyc, 7);
    run_instr(32'h0020A023, 0, 0, 0, 0, 2, cyc, pcw);
    check_int("lat2_store_cycles", cyc, 5);

    // Randomized legal instructions on both latencies.
    for (int pass = 1; pass <= 2; pass++) begin
      logic [6:0] ops [9];
      ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
      do_reset();
      for (int n = 0; n < 30; n++) begin
        logic [31:0] r;
        logic [3:0]  f;
        r = $urandom();
        r[6:0] = ops[$urandom_range(0, 8)];
        f = 4'($urandom());
        run_instr(r, f[0], f[1], f[2], f[3], pass, cyc, pcw);
      end
    end

    // Reset during the store's MEM_WRITE cycle drops mem_write at once.
    do_reset();
    instr = 32'h0020A023;
    repeat (3) @(negedge clk);
    check_vec("store_mem_write", vec1,
              mk(ST_MEM_WRITE, 0, 1, 0 | 1, 0, 2'b00, 2'b00, 2'b00, 4'd0, 3'd0, 0, 0));
    reset = 1'b0;
    #1;
    check_vec("abort_outputs", vec1, '0);
    @(posedge clk);
    #1;
    check_vec("abort_after_edge", vec1, '0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_vec("abort_restart_fetch", vec1,
              mk(ST_FETCH, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 4'd0, 3'd0, 0, 0));

    // Illegal opcode: FETCH, DECODE, then TRAP with only illegal set.
    do_reset();
    instr = 32'h0000007F;
    #1;
    build(32'h0000007F, 0, 0, 0, 0, 1);
    check_vec("trap_fetch", vec1, exp_q[0]);
    @(negedge clk);
    check_vec("trap_decode", vec1, exp_q[1]);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      instr = $urandom();
      check_vec($sformatf("trap_hold%0d", k), vec1, exp_q[2]);
    end
    instr = 32'h002081B3;
    reset = 1'b0;
    #1;
    check_int("trap_illegal_in_reset", int'(illegal1), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_int("trap_illegal_cleared", int'(illegal1), 0);
    check_int("trap_state_fetch", int'(state_dbg1), int'(ST_FETCH));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
